mem_slot_scheduler: RTL and testbench

Time-slot scheduler for the shared 16-bit RAM/ROM bus of the compact-Mac core. It divides clk8 time into fixed two-cycle slots and decides which requester owns each one: CPU, video fetch, sound fetch, or internal/external floppy read. It drives the bus-ownership, load and acknowledge strobes consumed by the data controller and the address mux. It replaces ad-hoc phase decoding with one arbitration point that has bounded latency.

---
 rtl/mem_slot_pkg.sv | 46 ++++
 rtl/slot_pick.sv | 52 +++++
 rtl/mem_slot_scheduler.sv | 112 +++++++++++
 tb/tb_mem_slot_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_slot_pkg.sv
// mem_slot_pkg
// Shared definitions for the memory slot scheduler:
//   - owner_t    : slot owner codes, also used as the address-mux select
//   - SLOT_*     : encodings of the free-running {slotType, phase} counter
//   - REQ_*      : bit positions of each requester in the request vectors
//   - owner_mask : maps an owner code to its one-hot request bit
package mem_slot_pkg;

    typedef enum logic [2:0] {
        OWN_NONE   = 3'd0,
        OWN_CPU    = 3'd1,
        OWN_VIDEO  = 3'd2,
        OWN_SOUND  = 3'd3,
        OWN_DSKINT = 3'd4,
        OWN_DSKEXT = 3'd5
    } owner_t;

    // {slotType, phase}: slotType 0 = A (DMA-class), 1 = B (CPU-class);
    // phase 0 = address, phase 1 = data.
    localparam logic [1:0] SLOT_A_ADDR = 2'b00;
    localparam logic [1:0] SLOT_A_DATA = 2'b01;
    localparam logic [1:0] SLOT_B_ADDR = 2'b10;
    localparam logic [1:0] SLOT_B_DATA = 2'b11;

    localparam int NUM_REQ    = 5;
    localparam int REQ_CPU    = 0;
    localparam int REQ_VIDEO  = 1;
    localparam int REQ_SOUND  = 2;
    localparam int REQ_DSKINT = 3;
    localparam int REQ_DSKEXT = 4;

    function automatic logic [NUM_REQ-1:0] owner_mask(input owner_t o);
        logic [NUM_REQ-1:0] m;
        m = '0;
        case (o)
            OWN_CPU:    m[REQ_CPU]    = 1'b1;
            OWN_VIDEO:  m[REQ_VIDEO]  = 1'b1;
            OWN_SOUND:  m[REQ_SOUND]  = 1'b1;
            OWN_DSKINT: m[REQ_DSKINT] = 1'b1;
            OWN_DSKEXT: m[REQ_DSKEXT] = 1'b1;
            default:    m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/slot_pick.sv
// slot_pick
// Combinational owner picker for the slot being entered.
// Ports:
//   eff_req    in  5  effective requests (req & ~served), REQ_* bit order
//   slot_type  in  1  0 = entering an A slot, 1 = entering a B slot
//   rr         in  1  disk round-robin state: 1 = external disk's turn
//   next_owner out 3  owner code for the slot being entered
// Parameters:
//   CPU_SPARE  CPU may use an A slot that no DMA requester wants
//   DSK_FAIR   round-robin between the two disks instead of internal-first
module slot_pick
    import mem_slot_pkg::*;
#(
    parameter bit CPU_SPARE = 1'b1,
    parameter bit DSK_FAIR  = 1'b1
) (
    input  logic [NUM_REQ-1:0] eff_req,
    input  logic               slot_type,
    input  logic               rr,
    output logic [2:0]         next_owner
);

    logic int_req;
    logic ext_req;

    assign int_req = eff_req[REQ_DSKINT];
    assign ext_req = eff_req[REQ_DSKEXT];

    always_comb begin
        next_owner = OWN_NONE;
        if (!slot_type) begin
            if (eff_req[REQ_VIDEO]) begin
                next_owner = OWN_VIDEO;
            end else if (eff_req[REQ_SOUND]) begin
                next_owner = OWN_SOUND;
            end else if (int_req || ext_req) begin
                // rr only matters when both disks contend in fair mode.
                if (DSK_FAIR && int_req && ext_req) begin
                    next_owner = rr ? OWN_DSKEXT : OWN_DSKINT;
                end else begin
                    next_owner = int_req ? OWN_DSKINT : OWN_DSKEXT;
                end
            end else if (CPU_SPARE && eff_req[REQ_CPU]) begin
                next_owner = OWN_CPU;
            end
        end else if (eff_req[REQ_CPU]) begin
            // DMA requesters never own a B slot.
            next_owner = OWN_CPU;
        end
    end

endmodule

// File: rtl/mem_slot_scheduler.sv
// mem_slot_scheduler
// Splits clk8 time into two-cycle slots (A = DMA-class, B = CPU-class) and
// decides which requester owns the shared RAM/ROM bus for each slot.
//
// Request/ack protocol: a requester holds its req high until it sees its
// one-cycle ack strobe. The owner is chosen on the edge entering phase 0
// from the effective requests (req & ~served). On the edge entering phase 1
// the owner's strobe fires only if its req is still high; otherwise the slot
// is wasted. After a strobe the requester is masked until its req is sampled
// low, so a late-dropping request is not served twice.
//
// Ports:
//   clk8            in   bus clock, all logic on posedge
//   _reset          in   asynchronous active-low reset
//   cpuReq, videoReq, soundReq, dskReqInt, dskReqExt  in  requests
//   owner           out 3  current slot owner (address-mux select)
//   cpuBusControl   out    owner is CPU
//   videoBusControl out    owner is video, sound or a disk
//   cpuAck, loadPixels, loadSound, dskReadAckInt, dskReadAckExt
//                   out    one-cycle data-valid strobes (phase 1 only)
//   slot            out 2  {slotType, phase} counter, for observation
module mem_slot_scheduler
    import mem_slot_pkg::*;
#(
    parameter bit CPU_SPARE = 1'b1,
    parameter bit DSK_FAIR  = 1'b1
) (
    input  logic       clk8,
    input  logic       _reset,
    input  logic       cpuReq,
    input  logic       videoReq,
    input  logic       soundReq,
    input  logic       dskReqInt,
    input  logic       dskReqExt,
    output logic [2:0] owner,
    output logic       cpuBusControl,
    output logic       videoBusControl,
    output logic       cpuAck,
    output logic       loadPixels,
    output logic       loadSound,
    output logic       dskReadAckInt,
    output logic       dskReadAckExt,
    output logic [1:0] slot
);

    logic [1:0]         cnt;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] served;
    logic [NUM_REQ-1:0] eff_req;
    logic [NUM_REQ-1:0] owner_req;
    logic [NUM_REQ-1:0] ack_q;
    logic               rr;
    logic               grant_edge;
    logic               entering_b;
    logic [2:0]         pick_owner;
    owner_t             owner_q;

    assign req       = {dskReqExt, dskReqInt, soundReq, videoReq, cpuReq};
    assign eff_req   = req & ~served;
    // The next edge enters phase 0 whenever we are currently in phase 1.
    assign grant_edge = (cnt == SLOT_A_DATA) || (cnt == SLOT_B_DATA);
    assign entering_b = (cnt == SLOT_A_DATA);
    // Owner's request bit, only if it is still asserted right now.
    assign owner_req = owner_mask(owner_q) & req;

    slot_pick #(
        .CPU_SPARE (CPU_SPARE),
        .DSK_FAIR  (DSK_FAIR)
    ) u_pick (
        .eff_req    (eff_req),
        .slot_type  (entering_b),
        .rr         (rr),
        .next_owner (pick_owner)
    );

    always_ff @(posedge clk8 or negedge _reset) begin
        if (!_reset) begin
            cnt     <= SLOT_A_ADDR;
            owner_q <= OWN_NONE;
            ack_q   <= '0;
            served  <= '0;
            rr      <= 1'b0;
        end else begin
            cnt <= cnt + 2'd1;
            if (grant_edge) begin
                owner_q <= owner_t'(pick_owner);
                ack_q   <= '0;
                served  <= served & req;
                // rr remembers the last disk granted; non-disk grants keep it.
                if (pick_owner == OWN_DSKINT) begin
                    rr <= 1'b1;
                end else if (pick_owner == OWN_DSKEXT) begin
                    rr <= 1'b0;
                end
            end else begin
                ack_q  <= owner_req;
                served <= (served & req) | owner_req;
            end
        end
    end

    assign owner           = owner_q;
    assign cpuBusControl   = (owner_q == OWN_CPU);
    assign videoBusControl = (owner_q != OWN_NONE) && (owner_q != OWN_CPU);
    assign cpuAck          = ack_q[REQ_CPU];
    assign loadPixels      = ack_q[REQ_VIDEO];
    assign loadSound       = ack_q[REQ_SOUND];
    assign dskReadAckInt   = ack_q[REQ_DSKINT];
    assign dskReadAckExt   = ack_q[REQ_DSKEXT];
    assign slot            = cnt;

endmodule

// File: tb/tb_mem_slot_scheduler.sv
// Bench for mem_slot_scheduler. Two instances share one set of request
// inputs: dut_a uses CPU_SPARE=1/DSK_FAIR=1, dut_b uses CPU_SPARE=0/DSK_FAIR=0.
// A slot-level reference model (one per configuration) predicts every output.
module tb_mem_slot_scheduler;

    localparam int R_CPU  = 0;
    localparam int R_VID  = 1;
    localparam int R_SND  = 2;
    localparam int R_DINT = 3;
    localparam int R_DEXT = 4;

    // ---------------- clock / reset ----------------
    logic clk8   = 1'b0;
    logic _reset = 1'b1;
    always #5 clk8 = ~clk8;

    logic cpu_req   = 1'b0;
    logic video_req = 1'b0;
    logic sound_req = 1'b0;
    logic dsk_int   = 1'b0;
    logic dsk_ext   = 1'b0;

    logic [2:0] a_owner, b_owner;
    logic [1:0] a_slot, b_slot;
    logic a_cpu_bus, a_vid_bus, a_cpu_ack, a_pix, a_snd, a_dint, a_dext;
    logic b_cpu_bus, b_vid_bus, b_cpu_ack, b_pix, b_snd, b_dint, b_dext;

    mem_slot_scheduler #(.CPU_SPARE(1'b1), .DSK_FAIR(1'b1)) dut_a (
        .clk8(clk8), ._reset(_reset),
        .cpuReq(cpu_req), .videoReq(video_req), .soundReq(sound_req),
        .dskReqInt(dsk_int), .dskReqExt(dsk_ext),
        .owner(a_owner), .cpuBusControl(a_cpu_bus), .videoBusControl(a_vid_bus),
        .cpuAck(a_cpu_ack), .loadPixels(a_pix), .loadSound(a_snd),
        .dskReadAckInt(a_dint), .dskReadAckExt(a_dext), .slot(a_slot)
    );

    mem_slot_scheduler #(.CPU_SPARE(1'b0), .DSK_FAIR(1'b0)) dut_b (
        .clk8(clk8), ._reset(_reset),
        .cpuReq(cpu_req), .videoReq(video_req), .soundReq(sound_req),
        .dskReqInt(dsk_int), .dskReqExt(dsk_ext),
        .owner(b_owner), .cpuBusControl(b_cpu_bus), .videoBusControl(b_vid_bus),
        .cpuAck(b_cpu_ack), .loadPixels(b_pix), .loadSound(b_snd),
        .dskReadAckInt(b_dint), .dskReadAckExt(b_dext), .slot(b_slot)
    );

    // ---------------- bookkeeping ----------------
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Position within the 4-cycle slot pair, owner code (0 = none, else
    // requester index + 1), per-requester "already served" flags, disk turn.
    int m_pos[2];
    int m_owner[2];
    bit m_served[2][5];
    bit m_ext_turn[2];
    int m_ack[2];
    bit cfg_spare[2] = '{1'b1, 1'b0};
    bit cfg_fair[2]  = '{1'b1, 1'b0};

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_pos[c] = 0;
            m_owner[c] = 0;
            m_ext_turn[c] = 1'b0;
            m_ack[c] = -1;
            for (int i = 0; i < 5; i++) m_served[c][i] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit r[5];
        int order[$];
        int pick;
        int new_pos;
        r[R_CPU] = cpu_req; r[R_VID] = video_req; r[R_SND] = sound_req;
        r[R_DINT] = dsk_int; r[R_DEXT] = dsk_ext;
        for (int c = 0; c < 2; c++) begin
            new_pos = (m_pos[c] + 1) % 4;
            m_ack[c] = -1;
            if (new_pos % 2 == 0) begin
                // slot start: walk the preference list for this slot kind
                order.delete();
                if (new_pos == 0) begin
                    order.push_back(R_VID);
                    order.push_back(R_SND);
                    if (cfg_fair[c] && m_ext_turn[c]) begin
                        order.push_back(R_DEXT); order.push_back(R_DINT);
                    end else begin
                        order.push_back(R_DINT); order.push_back(R_DEXT);
                    end
                    if (cfg_spare[c]) order.push_back(R_CPU);
                end else begin
                    order.push_back(R_CPU);
                end
                pick = -1;
                foreach (order[k])
                    if (pick < 0 && r[order[k]] && !m_served[c][order[k]]) pick = order[k];
                m_owner[c] = pick + 1;
                if (pick == R_DINT) m_ext_turn[c] = 1'b1;
                if (pick == R_DEXT) m_ext_turn[c] = 1'b0;
            end else if (m_owner[c] != 0 && r[m_owner[c] - 1]) begin
                m_ack[c] = m_owner[c] - 1;
            end
            for (int i = 0; i < 5; i++) begin
                if (!r[i]) m_served[c][i] = 1'b0;
                if (m_ack[c] == i) m_served[c][i] = 1'b1;
            end
            m_pos[c] = new_pos;
        end
    endtask

    function automatic logic [11:0] model_vec(input int c);
        logic [4:0] st;
        logic [2:0] own;
        st = '0;
        if (m_ack[c] >= 0) st[4 - m_ack[c]] = 1'b1;
        own = 3'(m_owner[c]);
        return {2'(m_pos[c]), own, own == 3'd1, own >= 3'd2, st};
    endfunction

    function automatic logic [11:0] dut_vec(input int c);
        if (c == 0)
            return {a_slot, a_owner, a_cpu_bus, a_vid_bus, a_cpu_ack, a_pix, a_snd, a_dint, a_dext};
        return {b_slot, b_owner, b_cpu_bus, b_vid_bus, b_cpu_ack, b_pix, b_snd, b_dint, b_dext};
    endfunction

    // ---------------- driver tasks ----------------
    // One clock: model advances with the inputs present at the edge,
    // outputs are compared on the following falling edge.
    task automatic cycle();
        @(posedge clk8);
        model_step();
        @(negedge clk8);
        check("cycle_a", 32'(dut_vec(0)), 32'(model_vec(0)));
        check("cycle_b", 32'(dut_vec(1)), 32'(model_vec(1)));
    endtask

    task automatic do_reset();
        _reset = 1'b0;
        model_reset();
        #1;
        check("reset_async_a", 32'(dut_vec(0)), 32'(model_vec(0)));
        check("reset_async_b", 32'(dut_vec(1)), 32'(model_vec(1)));
        repeat (2) @(posedge clk8);
        @(negedge clk8);
        check("reset_hold_a", 32'(dut_vec(0)), 32'h0);
        check("reset_hold_b", 32'(dut_vec(1)), 32'h0);
        _reset = 1'b1;
    endtask

    task automatic set_req(input logic [4:0] v);
        {cpu_req, video_req, sound_req, dsk_int, dsk_ext} = v;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [4:0] in;    // {cpu, video, sound, dint, dext}
        logic [1:0] slot;
        logic [2:0] own;
        logic [4:0] st;    // {cpuAck, loadPixels, loadSound, dskInt, dskExt}
    } vec_t;

    vec_t tbl[21];

    // Scoreboard for disk ack order: 0 = internal, 1 = external.
    logic [0:0] exp_qa[$];
    logic [0:0] exp_qb[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int pix_cnt, cpu_cnt, na, nb, lat_a, lat_b;
        logic [0:0] e;

        tbl[0]  = '{5'b10000, 2'b01, 3'd0, 5'b00000};
        tbl[1]  = '{5'b10000, 2'b10, 3'd1, 5'b00000};
        tbl[2]  = '{5'b11000, 2'b11, 3'd1, 5'b10000};
        tbl[3]  = '{5'b11000, 2'b00, 3'd2, 5'b00000};
        tbl[4]  = '{5'b11000, 2'b01, 3'd2, 5'b01000};
        tbl[5]  = '{5'b10100, 2'b10, 3'd0, 5'b00000};
        tbl[6]  = '{5'b00100, 2'b11, 3'd0, 5'b00000};
        tbl[7]  = '{5'b10100, 2'b00, 3'd3, 5'b00000};
        tbl[8]  = '{5'b10000, 2'b01, 3'd3, 5'b00000};
        tbl[9]  = '{5'b10011, 2'b10, 3'd1, 5'b00000};
        tbl[10] = '{5'b00011, 2'b11, 3'd1, 5'b00000};
        tbl[11] = '{5'b00011, 2'b00, 3'd4, 5'b00000};
        tbl[12] = '{5'b00011, 2'b01, 3'd4, 5'b00010};
        tbl[13] = '{5'b00001, 2'b10, 3'd0, 5'b00000};
        tbl[14] = '{5'b00011, 2'b11, 3'd0, 5'b00000};
        tbl[15] = '{5'b00011, 2'b00, 3'd5, 5'b00000};
        tbl[16] = '{5'b00011, 2'b01, 3'd5, 5'b00001};
        tbl[17] = '{5'b00000, 2'b10, 3'd0, 5'b00000};
        tbl[18] = '{5'b10000, 2'b11, 3'd0, 5'b00000};
        tbl[19] = '{5'b10000, 2'b00, 3'd1, 5'b00000};
        tbl[20] = '{5'b10000, 2'b01, 3'd1, 5'b10000};

        #2;
        do_reset();

        // idle: 16 cycles with nothing requested
        set_req(5'b00000);
        repeat (16) cycle();

        // table-driven sequence from a fresh reset
        do_reset();
        for (int i = 0; i < 21; i++) begin
            set_req(tbl[i].in);
            cycle();
            check($sformatf("tbl[%0d]", i), 32'(dut_vec(0)),
                  32'({tbl[i].slot, tbl[i].own, tbl[i].own == 3'd1, tbl[i].own >= 3'd2, tbl[i].st}));
        end

        // video + cpu, each dropped for one cycle after its strobe
        do_reset();
        set_req(5'b11000);
        pix_cnt = 0;
        cpu_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            cycle();
            if (a_pix) begin
                pix_cnt++;
                check("pix_phase", 32'(a_slot), 32'd1);
            end
            if (a_cpu_ack) begin
                cpu_cnt++;
                check("cpu_ack_phase", 32'(a_slot), 32'd3);
            end
            video_req = (m_ack[0] != R_VID);
            cpu_req   = (m_ack[0] != R_CPU);
        end
        check("pix_count", pix_cnt, 7);
        check("cpu_b_count", cpu_cnt, 8);

        // both disks re-requested after every ack
        do_reset();
        set_req(5'b00011);
        for (int i = 0; i < 12; i++) begin
            exp_qa.push_back(1'(i % 2));
            exp_qb.push_back(1'b0);
        end
        na = 0;
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (a_dint || a_dext) begin
                na++;
                e = exp_qa.pop_front();
                check("dsk_order_a", 32'(a_dext), 32'(e));
            end
            if (b_dint || b_dext) begin
                nb++;
                e = exp_qb.pop_front();
                check("dsk_order_b", 32'(b_dext), 32'(e));
            end
            dsk_int = !(m_ack[0] == R_DINT || m_ack[1] == R_DINT);
            dsk_ext = !(m_ack[0] == R_DEXT || m_ack[1] == R_DEXT);
        end
        check("dsk_count_a", na, 9);
        check("dsk_count_b", nb, 9);

        // cpu held 12 cycles: one ack; drop and re-raise: quick second ack
        do_reset();
        set_req(5'b10000);
        na = 0;
        nb = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            na += int'(a_cpu_ack);
            nb += int'(b_cpu_ack);
        end
        check("cpu_hold_a", na, 1);
        check("cpu_hold_b", nb, 1);
        cpu_req = 1'b0;
        cycle();
        cpu_req = 1'b1;
        lat_a = 99;
        lat_b = 99;
        for (int n = 1; n <= 8; n++) begin
            cycle();
            if (a_cpu_ack && lat_a == 99) lat_a = n;
            if (b_cpu_ack && lat_b == 99) lat_b = n;
        end
        check("cpu_rereq_lat_a", lat_a, 2);
        check("cpu_rereq_lat_b", lat_b, 2);

        // cpu raised just after a B grant: spare A slot vs worst case
        do_reset();
        set_req(5'b00000);
        cycle();
        cycle();
        cpu_req = 1'b1;
        lat_a = 99;
        lat_b = 99;
        for (int n = 1; n <= 8; n++) begin
            cycle();
            if (a_cpu_ack && lat_a == 99) lat_a = n;
            if (b_cpu_ack && lat_b == 99) lat_b = n;
        end
        check("cpu_worst_lat_a", lat_a, 3);
        check("cpu_worst_lat_b", lat_b, 5);

        // reset during A phase 0 with video granted
        do_reset();
        set_req(5'b11000);
        for (int k = 0; k < 8 && !(m_pos[0] == 0 && m_owner[0] == 2); k++) cycle();
        check("vid_granted", 32'(a_owner), 32'd2);
        do_reset();
        cycle();
        cycle();
        check("post_rst_b_grant", 32'(a_owner), 32'd1);
        cycle();
        check("post_rst_cpu_ack", 32'(a_cpu_ack), 32'd1);

        // randomized traffic
        do_reset();
        set_req(5'b00000);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) cpu_req   = ~cpu_req;
            if ($urandom_range(0, 3) == 0) video_req = ~video_req;
            if ($urandom_range(0, 5) == 0) sound_req = ~sound_req;
            if ($urandom_range(0, 3) == 0) dsk_int   = ~dsk_int;
            if ($urandom_range(0, 3) == 0) dsk_ext   = ~dsk_ext;
            if ($urandom_range(0, 199) == 0) do_reset();
            else cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
